// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, widths and rounding/saturation helper for the DF-II IIR engine
package iir_pkg;
  localparam int DATA_W    = 32;
  localparam int FRAC_W    = 16;
  localparam int ACC_W     = 72;
  localparam int MAX_ORDER = 8;

  localparam logic [1:0] COEF_SEL_A   = 2'd0;
  localparam logic [1:0] COEF_SEL_B   = 2'd1;
  localparam logic [1:0] COEF_SEL_OFS = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, FB = 2'd1, FF = 2'd2, OUT = 2'd3} state_e;

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] val;
  } rs_t;

  localparam logic signed [ACC_W-1:0] HALF_LSB =
    {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Half-up rounding: add half an LSB, then arithmetic shift floors the result.
  function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    rs_t res;
    r = (acc + HALF_LSB) >>> FRAC_W;
    res.sat = 1'b0;
    res.val = r[DATA_W-1:0];
    if (r > SAT_MAX) begin
      res.sat = 1'b1;
      res.val = SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      res.sat = 1'b1;
      res.val = SAT_MIN[DATA_W-1:0];
    end
    return res;
  endfunction
endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - single signed multiplier feeding a wide accumulator
// sum_o is the accumulator value including the current product, so the last step can be rounded the same cycle.
module iir_mac
  import iir_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     ld_i,
  input  logic signed [ACC_W-1:0]  ld_val_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  sum_o
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  always_comb begin
    prod  = a_i * b_i;
    sum_o = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_d = acc_q;
    if (ld_i)       acc_d = ld_val_i;
    else if (clr_i) acc_d = '0;
    else if (en_i)  acc_d = sum_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

// File: rtl/iir_df2_engine.sv
// rtl/iir_df2_engine.sv - time-multiplexed direct-form-II IIR section with coefficient load and saturation
// Sequence per sample: IDLE (accept) -> FB (ORDER feedback MACs) -> FF (ORDER+1 feedforward MACs) -> OUT.
module iir_df2_engine
  import iir_pkg::*;
#(
  parameter int ORDER = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] w_out,
  input  logic              coef_we,
  input  logic [1:0]        coef_sel,
  input  logic [2:0]        coef_idx,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_err,
  input  logic              clear,
  output logic              sat_flag
);
  localparam logic [3:0] ORD = 4'(ORDER);

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic signed [DATA_W-1:0] a_q  [0:MAX_ORDER];
  logic signed [DATA_W-1:0] b_q  [0:MAX_ORDER];
  logic signed [DATA_W-1:0] dl_q [0:MAX_ORDER];
  logic signed [DATA_W-1:0] ofs_q, w_q, y_q, ofs_eff, mul_a, mul_b;
  logic sat_q, err_q, accept, last_step, idx_ok, wr_ok;
  logic mac_ld, mac_en, mac_clr;
  logic [3:0] widx;
  logic signed [DATA_W:0]   xo;
  logic signed [ACC_W-1:0]  ld_val, mac_sum;
  rs_t rs;

  assign widx      = {1'b0, coef_idx};
  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = ((state_q == FB) || (state_q == FF)) && (idx_q == ORD);

  always_comb begin
    case (coef_sel)
      COEF_SEL_A:   idx_ok = (widx != 4'd0) && (widx <= ORD);
      COEF_SEL_B:   idx_ok = (widx <= ORD);
      COEF_SEL_OFS: idx_ok = 1'b1;
      default:      idx_ok = 1'b0;
    endcase
  end
  assign wr_ok = coef_we && (state_q == IDLE) && idx_ok;

  // A same-cycle offset write must already apply to the sample being accepted.
  assign ofs_eff = (wr_ok && (coef_sel == COEF_SEL_OFS)) ? coef_data : ofs_q;
  assign xo      = {x_in[DATA_W-1], x_in} + {ofs_eff[DATA_W-1], ofs_eff};
  assign ld_val  = {{(ACC_W-DATA_W-1-FRAC_W){xo[DATA_W]}}, xo, {FRAC_W{1'b0}}};
  assign rs      = round_sat(mac_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = FB;
        idx_d   = 4'd1;
      end
      FB: begin
        idx_d = idx_q + 4'd1;
        if (last_step) begin
          state_d = FF;
          idx_d   = 4'd0;
        end
      end
      FF: begin
        idx_d = idx_q + 4'd1;
        if (last_step) begin
          state_d = OUT;
          idx_d   = 4'd0;
        end
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    mac_ld    = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state_q)
      IDLE: mac_ld = accept;
      FB: begin
        mac_en  = 1'b1;
        mac_clr = last_step;
        mul_a   = a_q[idx_q];
        mul_b   = dl_q[idx_q - 4'd1];
      end
      FF: begin
        mac_en  = 1'b1;
        mac_clr = last_step;
        mul_a   = b_q[idx_q];
        mul_b   = (idx_q == 4'd0) ? w_q : dl_q[idx_q - 4'd1];
      end
      default: ;
    endcase
  end

  iir_mac u_mac (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .ld_i     (mac_ld),
    .ld_val_i (ld_val),
    .a_i      (mul_a),
    .b_i      (mul_b),
    .sum_o    (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= MAX_ORDER; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        dl_q[k] <= '0;
      end
      ofs_q <= '0;
      w_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= coef_we && !wr_ok;
      if (wr_ok) begin
        case (coef_sel)
          COEF_SEL_A: a_q[widx] <= coef_data;
          COEF_SEL_B: b_q[widx] <= coef_data;
          default:    ofs_q     <= coef_data;
        endcase
      end
      if (last_step && rs.sat) sat_q <= 1'b1;
      if (last_step && (state_q == FB)) w_q <= rs.val;
      if (last_step && (state_q == FF)) begin
        y_q     <= rs.val;
        dl_q[0] <= w_q;
        for (int k = 1; k <= MAX_ORDER; k++) begin
          if (k < ORDER) dl_q[4'(k)] <= dl_q[4'(k-1)];
        end
      end
      if (clear && (state_q == IDLE)) begin
        for (int k = 0; k <= MAX_ORDER; k++) dl_q[k] <= '0;
        sat_q <= 1'b0;
      end
    end
  end

  assign y_out    = y_q;
  assign w_out    = w_q;
  assign coef_err = err_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_iir_df2_engine.sv
// tb/tb_iir_df2_engine.sv - randomized self-checking bench for iir_df2_engine
module tb_iir_df2_engine;
  localparam int ORDER = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, coef_we, coef_err, clear, sat_flag;
  logic [31:0] x_in, y_out, w_out, coef_data;
  logic [1:0]  coef_sel;
  logic [2:0]  coef_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [31:0] m_a [0:8];
  logic signed [31:0] m_b [0:8];
  logic signed [31:0] m_hist [0:8];
  logic signed [31:0] m_ofs;
  bit m_sat;

  always #5 clk = ~clk;

  iir_df2_engine #(.ORDER(ORDER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .w_out     (w_out),
    .coef_we   (coef_we),
    .coef_sel  (coef_sel),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .clear     (clear),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k <= 8; k++) begin
      m_a[k] = 0;
      m_b[k] = 0;
      m_hist[k] = 0;
    end
    m_ofs = 0;
    m_sat = 0;
  endfunction

  function automatic bit model_write(input logic [1:0] sel, input logic [2:0] idx, input logic [31:0] d);
    int k;
    k = int'(idx);
    if (sel == 2'd0 && k >= 1 && k <= ORDER) begin m_a[k] = d; return 1'b1; end
    if (sel == 2'd1 && k <= ORDER) begin m_b[k] = d; return 1'b1; end
    if (sel == 2'd2) begin m_ofs = d; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [31:0] sat_model(input logic signed [127:0] acc);
    logic signed [127:0] r, hi, lo;
    hi = 128'sh7FFF_FFFF;
    lo = -hi - 128'sd1;
    r = (acc + 128'sd32768) >>> 16;
    if (r > hi) begin m_sat = 1'b1; return 32'h7FFF_FFFF; end
    if (r < lo) begin m_sat = 1'b1; return 32'h8000_0000; end
    return r[31:0];
  endfunction

  function automatic void model_step(input logic signed [31:0] x, output logic [31:0] ey, output logic [31:0] ew);
    logic signed [127:0] acc, t;
    logic signed [31:0] wn;
    acc = x;
    t = m_ofs;
    acc = (acc + t) * 65536;
    for (int k = 1; k <= ORDER; k++) acc = acc + m_a[k] * m_hist[k-1];
    ew = sat_model(acc);
    wn = ew;
    acc = m_b[0] * wn;
    for (int k = 1; k <= ORDER; k++) acc = acc + m_b[k] * m_hist[k-1];
    ey = sat_model(acc);
    for (int k = ORDER - 1; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = wn;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0; clear = 1'b0;
    x_in = '0; coef_sel = '0; coef_idx = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [2:0] idx, input logic [31:0] d);
    bit ok;
    coef_we = 1'b1; coef_sel = sel; coef_idx = idx; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
    ok = model_write(sel, idx, d);
    check("coef_err", 64'(coef_err), 64'(!ok));
  endtask

  // Caller may pre-set coef_we/clear for the accept cycle; they are dropped after it.
  task automatic sample(input logic [31:0] x, input int stall, input bit busy_wr,
                        output logic [31:0] gy, output logic [31:0] gw);
    logic [31:0] ey, ew;
    int cyc;
    bit rdy_seen;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; x_in = x;
    @(negedge clk);
    coef_we = 1'b0; clear = 1'b0; x_in = $urandom; cyc = 1; rdy_seen = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1;
      if (busy_wr && cyc == 2) begin
        check("coef_err_busy", 64'(coef_err), 64'd1);
        coef_we = 1'b0;
      end
      if (busy_wr && cyc == 1) begin
        coef_we = 1'b1; coef_sel = 2'd1; coef_idx = 3'd0; coef_data = 32'h0005_5555;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'(2*ORDER+2));
    check("in_ready_busy", 64'(rdy_seen), 64'd0);
    model_step(x, ey, ew);
    gy = y_out; gw = w_out;
    check("y_out", 64'(y_out), 64'(ey));
    check("w_out", 64'(w_out), 64'(ew));
    check("sat_flag", 64'(sat_flag), 64'(m_sat));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 64'({out_valid, in_ready}), 64'b10);
      check("stall_y", 64'(y_out), 64'(gy));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", 64'({out_valid, in_ready}), 64'b01);
  endtask

  task automatic impulse();
    logic [31:0] gy, gw, ey, ew;
    wr(2'd0, 3'd1, 32'h0000_8000);
    wr(2'd1, 3'd0, 32'h0001_0000);
    wr(2'd1, 3'd1, 32'h0001_0000);
    for (int i = 0; i < 3; i++) begin
      sample((i == 0) ? 32'h1_0000 : 32'h0, 0, 1'b0, gy, gw);
      ey = (i == 0) ? 32'h1_0000 : (i == 1) ? 32'h1_8000 : 32'hC000;
      ew = (i == 0) ? 32'h1_0000 : (i == 1) ? 32'h8000 : 32'h4000;
      check("impulse_y", 64'(gy), 64'(ey));
      check("impulse_w", 64'(gw), 64'(ew));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gy, gw, ey, ew, xr, v;
    int cyc, first, nout;
    bit seen;

    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y_out), 64'd0);
    check("rst_w", 64'(w_out), 64'd0);
    check("rst_coef_err", 64'(coef_err), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);

    impulse();
    sample(32'h0002_0000, 5, 1'b0, gy, gw);

    // randomized coefficients and samples
    for (int k = 1; k <= ORDER; k++) begin
      v = $urandom_range(0, 32'hC000) - 32'h6000;
      wr(2'd0, 3'(k), v);
    end
    for (int k = 0; k <= ORDER; k++) begin
      v = $urandom_range(0, 32'h4_0000) - 32'h2_0000;
      wr(2'd1, 3'(k), v);
    end
    v = $urandom_range(0, 32'h20_0000) - 32'h10_0000;
    wr(2'd2, 3'd0, v);
    for (int i = 0; i < 16; i++) begin
      xr = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000);
      sample(xr, 0, 1'b0, gy, gw);
    end

    // write guard: busy write dropped, illegal indices rejected in IDLE
    sample(32'h0003_0000, 0, 1'b1, gy, gw);
    sample(32'hFFFF_0000, 0, 1'b0, gy, gw);
    wr(2'd0, 3'd0, 32'h1234);
    wr(2'd1, 3'(ORDER + 1), 32'h1234);
    wr(2'd3, 3'd1, 32'h1234);

    // back-to-back throughput with in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1; x_in = 32'h0001_8000;
    cyc = 0; nout = 0; first = 0;
    while (nout < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        model_step(32'h0001_8000, ey, ew);
        check("thru_y", 64'(y_out), 64'(ey));
        if (nout > 0) check("thru_period", 64'(cyc - first), 64'(2*ORDER+3));
        first = cyc;
        nout++;
        if (nout == 3) in_valid = 1'b0;
      end
    end
    check("thru_count", 64'(nout), 64'd3);
    @(negedge clk);
    out_ready = 1'b0;

    // saturation, sticky flag and clear
    do_reset();
    wr(2'd2, 3'd0, 32'h7FFF_0000);
    wr(2'd1, 3'd0, 32'h0001_0000);
    sample(32'h7FFF_0000, 0, 1'b0, gy, gw);
    check("sat_pos_w", 64'(gw), 64'h7FFF_FFFF);
    check("sat_pos_y", 64'(gy), 64'h7FFF_FFFF);
    check("sat_pos_flag", 64'(sat_flag), 64'd1);
    wr(2'd2, 3'd0, 32'h8000_0000);
    sample(32'h8000_0000, 0, 1'b0, gy, gw);
    check("sat_neg_w", 64'(gw), 64'h8000_0000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_sat = 0;
    for (int k = 0; k <= 8; k++) m_hist[k] = 0;
    check("clear_sat", 64'(sat_flag), 64'd0);

    // write committed in the accept cycle is used by that sample
    wr(2'd2, 3'd0, 32'h0);
    coef_we = 1'b1; coef_sel = 2'd1; coef_idx = 3'd0; coef_data = 32'h0002_0000;
    void'(model_write(2'd1, 3'd0, 32'h0002_0000));
    sample(32'h0001_0000, 0, 1'b0, gy, gw);
    check("wr_accept_y", 64'(gy), 64'h0002_0000);

    // clear coinciding with accept runs on a zeroed delay line
    wr(2'd0, 3'd1, 32'h0001_0000);
    clear = 1'b1;
    for (int k = 0; k <= 8; k++) m_hist[k] = 0;
    m_sat = 0;
    sample(32'h0000_4000, 0, 1'b0, gy, gw);
    check("clear_accept_w", 64'(gw), 64'h4000);

    // reset in the middle of FF aborts the sample
    in_valid = 1'b1; x_in = 32'h0001_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (ORDER + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_out", 64'(seen), 64'd0);
    check("abort_y", 64'(y_out), 64'd0);
    impulse();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
